// File: rtl/tc_clk_pkg.sv
// tc_clk_pkg: default divider ratios, reset sequencer state type and counter width helper
package tc_clk_pkg;
  localparam int CPU_DIV    = 12;
  localparam int PIX_DIV    = 16;
  localparam int SND_DIV    = 24;
  localparam int RESET_HOLD = 1024;
  typedef enum logic {HOLD = 1'b0, RUN = 1'b1} rst_state_t;
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/tc_ce_divider.sv
// tc_ce_divider: modulo-DIV counter with up to two registered single-cycle tap enables
module tc_ce_divider
  import tc_clk_pkg::*;
#(
  parameter int DIV  = 2,
  parameter int NT   = 1,
  parameter int TAP  = DIV - 1,
  parameter int TAP2 = DIV - 1
) (
  input  logic          clk_sys,
  input  logic          clr,
  input  logic          hold,
  output logic [NT-1:0] ce
);
  localparam int W = cnt_w(DIV);
  logic [W-1:0] r_cnt;
  // count 0..DIV-1; clear dominates hold so a lost run always restarts from zero
  always_ff @(posedge clk_sys)
    r_cnt <= clr ? '0 : hold ? r_cnt : (r_cnt == W'(DIV - 1)) ? '0 : r_cnt + 1'b1;
  for (genvar t = 0; t < NT; t++) begin : g_tap
    // registered tap compare; a held counter must not emit, so hold masks the pulse
    always_ff @(posedge clk_sys)
      ce[t] <= ~clr & ~hold & (r_cnt == W'((t == 0) ? TAP : TAP2));
  end
endmodule

// File: rtl/tc_clock_enable_gen.sv
// tc_clock_enable_gen: lock-qualified core reset and phase-aligned clock enables; TC_CE_PAUSE_EN adds a pause port
module tc_clock_enable_gen #(
  parameter int CPU_DIV    = tc_clk_pkg::CPU_DIV,
  parameter int PIX_DIV    = tc_clk_pkg::PIX_DIV,
  parameter int SND_DIV    = tc_clk_pkg::SND_DIV,
  parameter int RESET_HOLD = tc_clk_pkg::RESET_HOLD
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic pll_locked,
`ifdef TC_CE_PAUSE_EN
  input  logic pause,
`endif
  output logic core_reset,
  output logic ce_cpu_phi1,
  output logic ce_cpu_phi2,
  output logic ce_pix,
  output logic ce_snd
);
  import tc_clk_pkg::*;
  localparam int HW = cnt_w(RESET_HOLD);
  logic [1:0]    r_sync;
  logic [HW-1:0] r_hold;
  rst_state_t    r_state;
  logic          w_run;
  logic          w_pause;
  logic [1:0]    w_cpu_ce;
  logic [0:0]    w_pix_ce;
  logic [0:0]    w_snd_ce;
  // two-flop synchronizer for the asynchronous lock flag
  always_ff @(posedge clk_sys)
    r_sync <= reset ? 2'b00 : {r_sync[0], pll_locked};
  assign w_run = r_sync[1] & ~reset;
`ifdef TC_CE_PAUSE_EN
  logic r_pause;
  // registered pause reaches the cpu and snd dividers in the same cycle, keeping their relative phase
  always_ff @(posedge clk_sys)
    r_pause <= reset ? 1'b0 : pause;
  assign w_pause = r_pause;
`else
  assign w_pause = 1'b0;
`endif
  // reset sequencer: keep core_reset high for RESET_HOLD run cycles, restart on any loss of run
  always_ff @(posedge clk_sys)
    if (!w_run) begin
      r_state <= HOLD;
      r_hold  <= '0;
    end else if (r_state == HOLD) begin
      r_hold  <= r_hold + 1'b1;
      r_state <= (r_hold == HW'(RESET_HOLD - 1)) ? RUN : HOLD;
    end
  assign core_reset = (r_state == HOLD);
  tc_ce_divider #(.DIV(CPU_DIV), .NT(2), .TAP(CPU_DIV - 1), .TAP2(CPU_DIV / 2 - 1)) u_cpu (
    .clk_sys(clk_sys), .clr(~w_run), .hold(w_pause), .ce(w_cpu_ce));
  tc_ce_divider #(.DIV(PIX_DIV)) u_pix (
    .clk_sys(clk_sys), .clr(~w_run), .hold(1'b0), .ce(w_pix_ce));
  tc_ce_divider #(.DIV(SND_DIV)) u_snd (
    .clk_sys(clk_sys), .clr(~w_run), .hold(w_pause), .ce(w_snd_ce));
  assign ce_cpu_phi1 = w_cpu_ce[0];
  assign ce_cpu_phi2 = w_cpu_ce[1];
  assign ce_pix      = w_pix_ce[0];
  assign ce_snd      = w_snd_ce[0];
endmodule

// File: tb/tb_tc_clock_enable_gen.sv
// tb_tc_clock_enable_gen: cycle model of the enable generator plus directed lock/reset/period scenarios
module tb_tc_clock_enable_gen;
  localparam int CPU_DIV = 12, PIX_DIV = 16, SND_DIV = 24, RESET_HOLD = 1024;
  logic clk_sys = 1'b0;
  logic reset = 1'b1;
  logic pll_locked = 1'b0;
  logic pause = 1'b0;
  logic core_reset, ce_cpu_phi1, ce_cpu_phi2, ce_pix, ce_snd;
  int n_checks = 0;
  int n_fail = 0;

  always #5 clk_sys = ~clk_sys;

  tc_clock_enable_gen dut (
    .clk_sys(clk_sys),
    .reset(reset),
    .pll_locked(pll_locked),
`ifdef TC_CE_PAUSE_EN
    .pause(pause),
`endif
    .core_reset(core_reset),
    .ce_cpu_phi1(ce_cpu_phi1),
    .ce_cpu_phi2(ce_cpu_phi2),
    .ce_pix(ce_pix),
    .ce_snd(ce_snd)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      if (n_fail <= 30) $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: k = cycles since run began, a = unpaused run cycles; enables follow from k and a modulo each ratio.
  initial begin
    bit lq1, lq2, pz, run, pz_now, p1, p2, pp, ps;
    bit e_rst, e_phi1, e_phi2, e_pix, e_snd;
    int k, a;
    lq1 = 0; lq2 = 0; pz = 0; k = 0; a = 0;
    p1 = 0; p2 = 0; pp = 0; ps = 0;
    @(posedge clk_sys);
    forever begin
      run    = lq2 && !reset;
      pz_now = pz;
      e_phi1 = run && !pz_now && (a % CPU_DIV == CPU_DIV - 1);
      e_phi2 = run && !pz_now && (a % CPU_DIV == CPU_DIV / 2 - 1);
      e_pix  = run && (k % PIX_DIV == PIX_DIV - 1);
      e_snd  = run && !pz_now && (a % SND_DIV == SND_DIV - 1);
      e_rst  = !(run && k >= RESET_HOLD - 1);
      k   = run ? k + 1 : 0;
      a   = run ? a + (pz_now ? 0 : 1) : 0;
      lq2 = reset ? 1'b0 : lq1;
      lq1 = reset ? 1'b0 : pll_locked;
      pz  = reset ? 1'b0 : pause;
      @(negedge clk_sys);
      chk("core_reset", core_reset, e_rst);
      chk("phi1", ce_cpu_phi1, e_phi1);
      chk("phi2", ce_cpu_phi2, e_phi2);
      chk("pix", ce_pix, e_pix);
      chk("snd", ce_snd, e_snd);
      chk("phi1_phi2_overlap", ce_cpu_phi1 & ce_cpu_phi2, 0);
      chk("back_to_back", (ce_cpu_phi1 & p1) | (ce_cpu_phi2 & p2) | (ce_pix & pp) | (ce_snd & ps), 0);
      p1 = ce_cpu_phi1; p2 = ce_cpu_phi2; pp = ce_pix; ps = ce_snd;
      @(posedge clk_sys);
    end
  end

  task automatic wait_fall(input string name, input int start, input int exp, output int n_pix, output int n_phi1);
    int n;
    n = start; n_pix = 0; n_phi1 = 0;
    while (n < 3000) begin
      @(negedge clk_sys);
      n++;
      if (!core_reset) break;
      n_pix += int'(ce_pix);
      n_phi1 += int'(ce_cpu_phi1);
    end
    chk(name, n, exp);
  endtask

  task automatic window(input int len, output int c1, output int c2, output int cp, output int cs, output int cal);
    int last1;
    c1 = 0; c2 = 0; cp = 0; cs = 0; cal = 0; last1 = -1;
    for (int i = 0; i < len; i++) begin
      @(negedge clk_sys);
      if (ce_cpu_phi1) last1 = i;
      if (ce_cpu_phi2 && last1 >= 0) chk("phi2_offset", i - last1, CPU_DIV / 2);
      c1 += int'(ce_cpu_phi1); c2 += int'(ce_cpu_phi2);
      cp += int'(ce_pix); cs += int'(ce_snd);
      cal += int'(ce_cpu_phi1 & ce_pix & ce_snd);
    end
  endtask

  initial begin
    int np, n1, c1, c2, cp, cs, cal;
    repeat (4) @(negedge clk_sys);
    reset = 1'b0;
    @(negedge clk_sys);
    chk("reset_core_reset", core_reset, 1);
    chk("reset_enables", {ce_cpu_phi1, ce_cpu_phi2, ce_pix, ce_snd}, 0);
    repeat (5) @(negedge clk_sys);
    chk("unlocked_core_reset", core_reset, 1);
    // power-up: lock rises, core_reset must fall after sync latency plus hold
    pll_locked = 1'b1;
    wait_fall("powerup_fall", 0, 2 + RESET_HOLD, np, n1);
    chk("hold_pix_pulses", np, 63);
    chk("hold_phi1_pulses", n1, 85);
    window(480, c1, c2, cp, cs, cal);
    chk("win_phi1", c1, 40);
    chk("win_phi2", c2, 40);
    chk("win_pix", cp, 30);
    chk("win_snd", cs, 20);
    chk("win_aligned", cal, 10);
    // lock loss in RUN and relock
    pll_locked = 1'b0;
    repeat (3) @(negedge clk_sys);
    chk("lockloss_core_reset", core_reset, 1);
    chk("lockloss_enables", {ce_cpu_phi1, ce_cpu_phi2, ce_pix, ce_snd}, 0);
    pll_locked = 1'b1;
    wait_fall("relock_fall", 0, 2 + RESET_HOLD, np, n1);
    chk("relock_pix_pulses", np, 63);
    // one-cycle reset pulse in RUN
    repeat (300) @(negedge clk_sys);
    reset = 1'b1;
    @(negedge clk_sys);
    reset = 1'b0;
    chk("pulse_core_reset", core_reset, 1);
    chk("pulse_enables", {ce_cpu_phi1, ce_cpu_phi2, ce_pix, ce_snd}, 0);
    wait_fall("pulse_fall", 1, 3 + RESET_HOLD, np, n1);
    chk("pulse_phi1_pulses", n1, 85);
    // randomized lock glitches, reset pulses and pauses, checked against the model every cycle
    for (int it = 0; it < 30; it++) begin
      repeat ($urandom_range(0, 80)) @(negedge clk_sys);
      case ($urandom_range(0, 3))
        0: begin
          pll_locked = 1'b0;
          repeat ($urandom_range(1, 6)) @(negedge clk_sys);
          pll_locked = 1'b1;
        end
        1: begin
          reset = 1'b1;
          repeat ($urandom_range(1, 3)) @(negedge clk_sys);
          reset = 1'b0;
        end
`ifdef TC_CE_PAUSE_EN
        2: pause = ~pause;
`endif
        default: ;
      endcase
    end
    pause = 1'b0;
    pll_locked = 1'b1;
    reset = 1'b0;
`ifdef TC_CE_PAUSE_EN
    for (int i = 0; i < 1100 && core_reset; i++) @(negedge clk_sys);
    chk("settle_run", core_reset, 0);
    pause = 1'b1;
    @(negedge clk_sys);
    c1 = 0; c2 = 0; cp = 0; cs = 0;
    for (int i = 0; i < 99; i++) begin
      @(negedge clk_sys);
      c1 += int'(ce_cpu_phi1); c2 += int'(ce_cpu_phi2);
      cp += int'(ce_pix); cs += int'(ce_snd);
    end
    pause = 1'b0;
    chk("pause_phi1", c1, 0);
    chk("pause_phi2", c2, 0);
    chk("pause_snd", cs, 0);
    chk("pause_pix_6_or_7", int'(cp == 6 || cp == 7), 1);
    cs = 0; cal = 0;
    for (int i = 0; i < 96; i++) begin
      @(negedge clk_sys);
      cs += int'(ce_snd);
      cal += int'(ce_snd & ~ce_cpu_phi1);
    end
    chk("resume_snd", cs, 4);
    chk("resume_snd_phi1_phase", cal, 0);
`endif
    repeat (50) @(negedge clk_sys);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
endmodule
